// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// State encoding and default parameter values live here.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b11
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester at or
// above the pointer, wrapping modulo NUM_REQ.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW-1:0] w_j;
    int            w_pos;

    // Scan from farthest offset to nearest so the nearest wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_pos   = 0;
        w_j     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = int'(i_ptr) + i;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_j = IW'(w_pos);
            if (i_req[w_j]) begin
                o_idx      = w_j;
                o_grant    = '0;
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among sources.
// Optional SEND watchdog compiled in with `define TX_ARB_TIMEOUT_EN.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_byte,
    input  logic                 transmit_ready,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 tx_ctrl,
    output logic [7:0]           tx_byte,
    output logic                 busy,
    output logic                 err
);

    localparam int IW = $clog2(NUM_REQ);

    state_t               r_state, w_state;
    logic [IW-1:0]        r_ptr, w_ptr, r_sel, w_sel;
    logic [7:0]           r_byte, w_byte;
    logic                 r_tx_ctrl, w_tx_ctrl;
    logic                 r_busy, w_busy;
    logic [NUM_REQ-1:0]   r_ack, w_ack, r_done, w_done;
    logic [NUM_REQ-1:0]   w_grant, w_sel_oh;
    logic [IW-1:0]        w_idx, w_ptr_inc;
    logic                 w_any;
    logic [7:0]           w_pick_byte;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 0) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_err, w_err;
    logic          w_expire;
    assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign err      = r_err;
`else
    assign err = 1'b0;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ptr_inc = (r_sel == IW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

    // Byte mux for the picked source and one-hot of the latched source.
    always_comb begin
        w_pick_byte = 8'h00;
        w_sel_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IW'(i)) w_pick_byte = req_byte[8*i +: 8];
            if (r_sel == IW'(i)) w_sel_oh[i] = 1'b1;
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_sel     = r_sel;
        w_byte    = r_byte;
        w_tx_ctrl = 1'b0;
        w_ack     = '0;
        w_done    = '0;
`ifdef TX_ARB_TIMEOUT_EN
        w_cnt     = r_cnt;
        w_err     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state   = SEND;
                    w_sel     = w_idx;
                    w_byte    = w_pick_byte;
                    w_tx_ctrl = 1'b1;
                    w_ack     = w_grant;
`ifdef TX_ARB_TIMEOUT_EN
                    w_cnt     = '0;
`endif
                end
            end
            SEND: begin
                w_tx_ctrl = 1'b1;
                if (transmit_ready) begin
                    w_state   = DONE;
                    w_done    = w_sel_oh;
                    w_tx_ctrl = 1'b0;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_state   = IDLE;
                    w_err     = 1'b1;
                    w_tx_ctrl = 1'b0;
                    w_ptr     = w_ptr_inc;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                w_state = IDLE;
                w_ptr   = w_ptr_inc;
            end
            default: w_state = IDLE;
        endcase
        w_busy = (w_state != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_byte    <= 8'h00;
            r_tx_ctrl <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= '0;
            r_done    <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_sel     <= w_sel;
            r_byte    <= w_byte;
            r_tx_ctrl <= w_tx_ctrl;
            r_busy    <= w_busy;
            r_ack     <= w_ack;
            r_done    <= w_done;
`ifdef TX_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt;
            r_err     <= w_err;
`endif
        end
    end

    assign ack     = r_ack;
    assign done    = r_done;
    assign tx_ctrl = r_tx_ctrl;
    assign tx_byte = r_byte;
    assign busy    = r_busy;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter.
// Observed vector: {ack, done, tx_ctrl, busy, err, tx_byte}.
module tb_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           nRst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_byte = '0;
    logic           transmit_ready = 1'b0;
    logic [N-1:0]   ack, done;
    logic           tx_ctrl, busy, err;
    logic [7:0]     tx_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .req            (req),
        .req_byte       (req_byte),
        .transmit_ready (transmit_ready),
        .ack            (ack),
        .done           (done),
        .tx_ctrl        (tx_ctrl),
        .tx_byte        (tx_byte),
        .busy           (busy),
        .err            (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        tick();
        tick();
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== 19'h0) begin
            errors++;
            $display("FAIL reset got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, 19'h0);
        end
        nRst = 1'b1;
        tick();
        checks++;
        if ({busy, tx_ctrl} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req got %b exp 00", {busy, tx_ctrl});
        end
    endtask

    task automatic test_single;
        logic [18:0] exp;
        req_byte = 32'h00A5_0000;
        req = 4'b0100;
        tick();
        for (int c = 1; c <= 5; c++) begin
            exp = {(c == 1) ? 4'b0100 : 4'b0000, 4'b0000,
                   1'b1, 1'b1, 1'b0, 8'hA5};
            checks++;
            if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
                errors++;
                $display("FAIL single_send c=%0d got %h exp %h", c,
                         {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
            end
            req = 4'b0000;
            if (c == 5) transmit_ready = 1'b1;
            tick();
        end
        transmit_ready = 1'b0;
        exp = {4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 8'hA5};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL single_done got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hA5};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL single_idle got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
    endtask

    task automatic test_wrap;
        req_byte = 32'h0000_3130;
        req = 4'b0011;
        tick();
        checks++;
        if ({ack, tx_ctrl, tx_byte} !== {4'b0001, 1'b1, 8'h30}) begin
            errors++;
            $display("FAIL wrap_grant0 got %h exp %h",
                     {ack, tx_ctrl, tx_byte}, {4'b0001, 1'b1, 8'h30});
        end
        req = 4'b0010;
        transmit_ready = 1'b1;
        tick();
        transmit_ready = 1'b0;
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_done0 got %b exp 0001", done);
        end
        checks++;
        if (ack !== 4'b0000) begin
            errors++;
            $display("FAIL no_grant_in_done got %b exp 0000", ack);
        end
        tick();
        tick();
        checks++;
        if ({ack, tx_ctrl, tx_byte} !== {4'b0010, 1'b1, 8'h31}) begin
            errors++;
            $display("FAIL wrap_grant1 got %h exp %h",
                     {ack, tx_ctrl, tx_byte}, {4'b0010, 1'b1, 8'h31});
        end
        req = 4'b0000;
        transmit_ready = 1'b1;
        tick();
        transmit_ready = 1'b0;
        tick();
    endtask

    task automatic test_byte_hold;
        req_byte = 32'h0000_1100;
        req = 4'b0010;
        tick();
        checks++;
        if ({ack, tx_byte} !== {4'b0010, 8'h11}) begin
            errors++;
            $display("FAIL hold_grant got %h exp %h",
                     {ack, tx_byte}, {4'b0010, 8'h11});
        end
        req_byte = 32'h0000_2200;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({tx_ctrl, tx_byte} !== {1'b1, 8'h11}) begin
                errors++;
                $display("FAIL hold_send c=%0d got %h exp %h", c,
                         {tx_ctrl, tx_byte}, {1'b1, 8'h11});
            end
        end
        transmit_ready = 1'b1;
        tick();
        transmit_ready = 1'b0;
        checks++;
        if ({done, tx_byte} !== {4'b0010, 8'h11}) begin
            errors++;
            $display("FAIL hold_done got %h exp %h",
                     {done, tx_byte}, {4'b0010, 8'h11});
        end
        tick();
    endtask

    task automatic test_rotation;
        int e;
        logic [3:0] ea;
        logic [7:0] eb;
        nRst = 1'b0;
        req_byte = 32'hD3C2_B1A0;
        req = 4'b1111;
        tick();
        nRst = 1'b1;
        for (int g = 0; g < 5; g++) begin
            e = g % 4;
            ea = 4'(1 << e);
            eb = 8'hA0 + 8'(8'h11 * e);
            tick();
            checks++;
            if ({ack, tx_ctrl, tx_byte} !== {ea, 1'b1, eb}) begin
                errors++;
                $display("FAIL rot_grant g=%0d got %h exp %h", g,
                         {ack, tx_ctrl, tx_byte}, {ea, 1'b1, eb});
            end
            tick();
            tick();
            transmit_ready = 1'b1;
            tick();
            transmit_ready = 1'b0;
            checks++;
            if (done !== ea) begin
                errors++;
                $display("FAIL rot_done g=%0d got %b exp %b", g, done, ea);
            end
            if (g == 4) req = 4'b0000;
            tick();
        end
    endtask

    task automatic test_reset_mid;
        req_byte = 32'h8877_0066;
        req = 4'b0100;
        tick();
        checks++;
        if ({ack, tx_byte} !== {4'b0100, 8'h77}) begin
            errors++;
            $display("FAIL rmid_grant got %h exp %h",
                     {ack, tx_byte}, {4'b0100, 8'h77});
        end
        tick();
        nRst = 1'b0;
        tick();
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== 19'h0) begin
            errors++;
            $display("FAIL rmid_reset got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, 19'h0);
        end
        nRst = 1'b1;
        req = 4'b1001;
        tick();
        checks++;
        if ({ack, done, tx_byte} !== {4'b0001, 4'b0000, 8'h66}) begin
            errors++;
            $display("FAIL rmid_next got %h exp %h",
                     {ack, done, tx_byte}, {4'b0001, 4'b0000, 8'h66});
        end
        req = 4'b0000;
        transmit_ready = 1'b1;
        tick();
        transmit_ready = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready;
        logic [18:0] exp;
        req = 4'b0000;
        transmit_ready = 1'b1;
        tick();
        tick();
        transmit_ready = 1'b0;
        exp = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h66};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL idle_ready got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
    endtask

    task automatic test_watchdog;
        logic [18:0] exp;
        req_byte = 32'h0000_005A;
        req = 4'b0001;
        tick();
        req = 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({tx_ctrl, busy, err, tx_byte} !== {3'b110, 8'h5A}) begin
                errors++;
                $display("FAIL wd_send c=%0d got %h exp %h", c,
                         {tx_ctrl, busy, err, tx_byte}, {3'b110, 8'h5A});
            end
            tick();
        end
        exp = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h5A};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL wd_expire got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
        tick();
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("FAIL wd_err_pulse got %b exp 00", {busy, err});
        end
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) transmit_ready = 1'b1;
            tick();
        end
        transmit_ready = 1'b0;
        exp = {4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h5A};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL wd_ready_wins got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            checks++;
            if ({tx_ctrl, busy, err} !== 3'b110) begin
                errors++;
                $display("FAIL nowd_send c=%0d got %b exp 110", c,
                         {tx_ctrl, busy, err});
            end
            if (c == 20) transmit_ready = 1'b1;
            tick();
        end
        transmit_ready = 1'b0;
        exp = {4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h5A};
        checks++;
        if ({ack, done, tx_ctrl, busy, err, tx_byte} !== exp) begin
            errors++;
            $display("FAIL nowd_done got %h exp %h",
                     {ack, done, tx_ctrl, busy, err, tx_byte}, exp);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_byte_hold();
        test_rotation();
        test_reset_mid();
        test_idle_ready();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
